uart_cmd_parser_mc: RTL and testbench

- Parametrised command-frame parser between the UART receiver's byte output and the multi-channel DDS/PWM/DAC control registers.
- Replaces the fixed 14-byte, fixed-channel decode with a configurable channel count and payload length.
- Adds CRC-8 checking, inter-byte timeout, broadcast addressing, a persistent per-channel enable register, and error reporting with counters.
- Frame format: HEADER, FUNC, CH, PAYLOAD_LEN payload bytes, CRC, FOOTER.

---
 rtl/uart_cmd_parser_mc.sv | 168 ++++++++++++++++
 tb/tb_uart_cmd_parser_mc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser_mc.sv
// Frame parser between the UART byte stream and the multi-channel control registers.
// Frames are HEADER, FUNC, CH, payload, CRC-8, FOOTER; good frames strobe cfg_valid, bad ones frame_err.
module uart_cmd_parser_mc #(
  parameter int         NUM_CH      = 4,
  parameter int         PAYLOAD_LEN = 10,
  parameter logic [7:0] HEADER      = 8'h55,
  parameter logic [7:0] FOOTER      = 8'hAA,
  parameter logic [7:0] BCAST_CH    = 8'hFF,
  parameter logic [7:0] CRC_POLY    = 8'h07,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     cfg_valid,
  output logic [7:0]               cfg_func,
  output logic [7:0]               cfg_ch,
  output logic [PAYLOAD_LEN*8-1:0] cfg_payload,
  output logic [NUM_CH-1:0]        ch_en,
  output logic                     frame_err,
  output logic [2:0]               err_code,
  output logic [15:0]              err_cnt,
  output logic                     busy
);
  localparam int PW = PAYLOAD_LEN * 8;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int IW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PAYLOAD_LEN - 1);

  localparam logic [2:0] E_CRC     = 3'd1;
  localparam logic [2:0] E_FOOTER  = 3'd2;
  localparam logic [2:0] E_CHANNEL = 3'd3;
  localparam logic [2:0] E_FUNC    = 3'd4;
  localparam logic [2:0] E_TIMEOUT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_FUNC, S_CH, S_PAY, S_CRC, S_FTR, S_COMMIT, S_ERR
  } state_t;

  state_t        state;
  logic [7:0]    crc;
  logic [7:0]    crc_next;
  logic [7:0]    func_r;
  logic [7:0]    ch_r;
  logic [PW-1:0] pay_r;
  logic [IW-1:0] idx;
  logic [TW-1:0] tmo_cnt;
  logic          waiting;
  logic          bad_ch;
  logic          bad_func;
  logic          err_now;
  logic [2:0]    err_val;

  function automatic logic [7:0] crc8_step(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  assign crc_next = crc8_step(crc, rx_data);
  assign waiting  = state inside {S_FUNC, S_CH, S_PAY, S_CRC, S_FTR};
  assign busy     = (state != S_IDLE);
  assign bad_ch   = (ch_r == 8'h00) || ((ch_r > 8'(NUM_CH)) && (ch_r != BCAST_CH));
  assign bad_func = (func_r != 8'h01) && (func_r != 8'h02);

  // Channel and function checks are resolved as the footer arrives so the
  // cfg_valid or frame_err pulse lands in the cycle right after it.
  always_comb begin
    err_now = 1'b0;
    err_val = 3'd0;
    if (waiting && !rx_valid && (tmo_cnt == TMO_LAST)) begin
      err_now = 1'b1;
      err_val = E_TIMEOUT;
    end else if (rx_valid && (state == S_CRC) && (rx_data != crc)) begin
      err_now = 1'b1;
      err_val = E_CRC;
    end else if (rx_valid && (state == S_FTR)) begin
      if (rx_data != FOOTER) begin
        err_now = 1'b1;
        err_val = E_FOOTER;
      end else if (bad_ch) begin
        err_now = 1'b1;
        err_val = E_CHANNEL;
      end else if (bad_func) begin
        err_now = 1'b1;
        err_val = E_FUNC;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      crc         <= '0;
      func_r      <= '0;
      ch_r        <= '0;
      pay_r       <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      cfg_valid   <= 1'b0;
      cfg_func    <= '0;
      cfg_ch      <= '0;
      cfg_payload <= '0;
      ch_en       <= '0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      err_cnt     <= '0;
    end else begin
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
      tmo_cnt   <= (waiting && !rx_valid && !err_now) ? tmo_cnt + 1'b1 : '0;
      if (err_now) begin
        frame_err <= 1'b1;
        err_code  <= err_val;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        state <= S_ERR;
      end else begin
        case (state)
          // COMMIT and ERR behave like IDLE so a header can follow with no gap.
          S_IDLE, S_COMMIT, S_ERR: begin
            crc   <= '0;
            idx   <= '0;
            state <= (rx_valid && (rx_data == HEADER)) ? S_FUNC : S_IDLE;
          end
          S_FUNC: if (rx_valid) begin
            func_r <= rx_data;
            crc    <= crc_next;
            state  <= S_CH;
          end
          S_CH: if (rx_valid) begin
            ch_r  <= rx_data;
            crc   <= crc_next;
            state <= S_PAY;
          end
          S_PAY: if (rx_valid) begin
            pay_r <= {pay_r[PW-9:0], rx_data};
            crc   <= crc_next;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= S_CRC;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          S_CRC: if (rx_valid) state <= S_FTR;
          S_FTR: if (rx_valid) begin
            state       <= S_COMMIT;
            cfg_valid   <= 1'b1;
            cfg_func    <= func_r;
            cfg_ch      <= ch_r;
            cfg_payload <= pay_r;
            if (func_r == 8'h02) begin
              for (int i = 0; i < NUM_CH; i++) begin
                if ((ch_r == BCAST_CH) || (ch_r == 8'(i + 1))) ch_en[i] <= pay_r[PW-8];
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_parser_mc.sv
// Self-checking bench for uart_cmd_parser_mc: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_uart_cmd_parser_mc;
  localparam int PL = 10;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         cfg_valid;
  logic [7:0]   cfg_func;
  logic [7:0]   cfg_ch;
  logic [79:0]  cfg_payload;
  logic [3:0]   ch_en;
  logic         frame_err;
  logic [2:0]   err_code;
  logic [15:0]  err_cnt;
  logic         busy;

  uart_cmd_parser_mc dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .cfg_valid   (cfg_valid),
    .cfg_func    (cfg_func),
    .cfg_ch      (cfg_ch),
    .cfg_payload (cfg_payload),
    .ch_en       (ch_en),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0]  frame_q [$];
  int          check_cnt  = 0;
  int          pass_cnt   = 0;
  int          valid_seen = 0;
  int          err_seen   = 0;
  int          exp_valid  = 0;
  int          exp_errs   = 0;
  logic [3:0]  m_en       = '0;
  logic [15:0] m_err_cnt  = '0;
  logic [2:0]  m_err_code = '0;
  logic [7:0]  m_func     = '0;
  logic [7:0]  m_ch       = '0;
  logic [79:0] m_pay      = '0;

  // Pulse monitor, sampled on the falling edge away from the active edge.
  always @(negedge sys_clk) begin
    if (cfg_valid) valid_seen++;
    if (frame_err) err_seen++;
  end

  task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bit-serial CRC-8 over frame_q[base .. base+n-1], MSB first, poly 0x07, init 0.
  function automatic logic [7:0] crc_of(input int base, input int n);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ frame_q[base+i][b];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    end
    return r;
  endfunction

  // Frame-level reference: decide the outcome of the frame at frame_q[base].
  task automatic model_frame(input int base);
    logic [7:0]  f, c;
    logic [79:0] p;
    logic [2:0]  code;
    f = frame_q[base+1];
    c = frame_q[base+2];
    p = '0;
    for (int i = 0; i < PL; i++) p = {p[71:0], frame_q[base+3+i]};
    code = 3'd0;
    if (frame_q[base+3+PL] != crc_of(base + 1, PL + 2)) code = 3'd1;
    else if (frame_q[base+4+PL] != 8'hAA) code = 3'd2;
    else if (c == 8'h00 || (c > 8'd4 && c != 8'hFF)) code = 3'd3;
    else if (f != 8'h01 && f != 8'h02) code = 3'd4;
    if (code != 3'd0) begin
      exp_errs++;
      m_err_code = code;
      if (m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
    end else begin
      exp_valid++;
      m_func = f;
      m_ch   = c;
      m_pay  = p;
      if (f == 8'h02) begin
        if (c == 8'hFF) m_en = {4{p[72]}};
        else m_en[int'(c) - 1] = p[72];
      end
    end
  endtask

  task automatic make_frame(input logic [7:0] f, input logic [7:0] c, input logic [79:0] p,
                            input logic [7:0] crc_xor, input logic [7:0] ftr, input bit do_model);
    int base;
    base = frame_q.size();
    frame_q.push_back(8'h55);
    frame_q.push_back(f);
    frame_q.push_back(c);
    for (int i = PL - 1; i >= 0; i--) frame_q.push_back(p[i*8 +: 8]);
    frame_q.push_back(crc_of(base + 1, PL + 2) ^ crc_xor);
    frame_q.push_back(ftr);
    if (do_model) model_frame(base);
  endtask

  // Drives the queued bytes with 'gap' idle cycles between them; limit<0 sends all.
  task automatic applyStimulus(input int gap, input int limit);
    int n;
    n = (limit < 0) ? frame_q.size() : limit;
    for (int i = 0; i < n; i++) begin
      rx_data  = frame_q[i];
      rx_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      if (gap > 0) begin
        rx_valid = 1'b0;
        repeat (gap) @(posedge sys_clk);
        #1;
      end
    end
    rx_valid = 1'b0;
    frame_q.delete();
  endtask

  task automatic check_state(input string tag);
    repeat (4) @(negedge sys_clk);
    checkOutput({tag, ".valid_cnt"}, 80'(valid_seen), 80'(exp_valid));
    checkOutput({tag, ".err_pulses"}, 80'(err_seen), 80'(exp_errs));
    checkOutput({tag, ".err_cnt"}, 80'(err_cnt), 80'(m_err_cnt));
    checkOutput({tag, ".err_code"}, 80'(err_code), 80'(m_err_code));
    checkOutput({tag, ".ch_en"}, 80'(ch_en), 80'(m_en));
    checkOutput({tag, ".cfg_func"}, 80'(cfg_func), 80'(m_func));
    checkOutput({tag, ".cfg_ch"}, 80'(cfg_ch), 80'(m_ch));
    checkOutput({tag, ".cfg_payload"}, cfg_payload, m_pay);
    checkOutput({tag, ".busy"}, 80'(busy), 80'(0));
  endtask

  initial begin
    logic [79:0] p;
    logic [7:0]  f, c, cx, ft;
    int          n, e0, v0;

    sys_rst_n = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    repeat (3) @(negedge sys_clk);
    checkOutput("rst.cfg_valid", 80'(cfg_valid), 80'(0));
    checkOutput("rst.cfg_payload", cfg_payload, 80'(0));
    checkOutput("rst.ch_en", 80'(ch_en), 80'(0));
    checkOutput("rst.frame_err", 80'(frame_err), 80'(0));
    checkOutput("rst.err_code", 80'(err_code), 80'(0));
    checkOutput("rst.err_cnt", 80'(err_cnt), 80'(0));
    checkOutput("rst.busy", 80'(busy), 80'(0));
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Enable channel 1; cfg_valid must appear in the cycle after the footer edge.
    make_frame(8'h02, 8'h01, 80'h01 << 72, 8'h00, 8'hAA, 1'b1);
    applyStimulus(0, -1);
    @(negedge sys_clk);
    checkOutput("enable.latency", 80'(cfg_valid), 80'(1));
    check_state("enable");
    checkOutput("enable.ch_en_lit", 80'(ch_en), 80'(4'b0001));

    make_frame(8'h01, 8'h02, 80'h00010001000000000100, 8'h00, 8'hAA, 1'b1);
    applyStimulus(1, -1);
    check_state("config");
    checkOutput("config.byte1", 80'(cfg_payload[71:64]), 80'(8'h01));

    make_frame(8'h02, 8'hFF, 80'h01 << 72, 8'h00, 8'hAA, 1'b1);
    applyStimulus(2, -1);
    check_state("bcast");
    checkOutput("bcast.ch_en_lit", 80'(ch_en), 80'(4'b1111));
    make_frame(8'h02, 8'h03, 80'h0, 8'h00, 8'hAA, 1'b1);
    applyStimulus(0, -1);
    check_state("ch3_off");
    checkOutput("ch3_off.ch_en_lit", 80'(ch_en), 80'(4'b1011));

    make_frame(8'h02, 8'h01, 80'h0, 8'h01, 8'hAA, 1'b1);
    applyStimulus(0, -1);
    check_state("bad_crc");
    make_frame(8'h02, 8'h01, 80'h0, 8'h00, 8'hAB, 1'b1);
    applyStimulus(0, -1);
    check_state("bad_ftr");
    make_frame(8'h02, 8'h05, 80'h0, 8'h00, 8'hAA, 1'b1);
    applyStimulus(0, -1);
    check_state("bad_ch");
    checkOutput("corrupt.err_cnt_lit", 80'(err_cnt), 80'(3));

    // Stall after the FUNC byte until the inter-byte timeout fires.
    frame_q.push_back(8'h55);
    frame_q.push_back(8'h02);
    applyStimulus(0, -1);
    e0 = err_seen;
    n  = 0;
    while (err_seen == e0 && n < 50100) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("tmo.seen", 80'(err_seen - e0), 80'(1));
    checkOutput("tmo.delay_in_window", 80'(n >= 49990 && n <= 50010), 80'(1));
    exp_errs++;
    m_err_cnt  = m_err_cnt + 16'd1;
    m_err_code = 3'd5;
    check_state("tmo");
    make_frame(8'h01, 8'h04, 80'h0123456789ABCDEF0011, 8'h00, 8'hAA, 1'b1);
    applyStimulus(1, -1);
    check_state("after_tmo");

    // Noise then two frames back to back with no gap.
    frame_q.push_back(8'h00);
    frame_q.push_back(8'hAA);
    make_frame(8'h02, 8'h02, 80'h01 << 72, 8'h00, 8'hAA, 1'b1);
    make_frame(8'h01, 8'h03, 80'hFEDCBA98765432100000, 8'h00, 8'hAA, 1'b1);
    applyStimulus(0, -1);
    check_state("b2b");

    // Reset mid-payload: the partial broadcast frame must not commit.
    v0 = valid_seen;
    make_frame(8'h02, 8'hFF, 80'h01 << 72, 8'h00, 8'hAA, 1'b0);
    applyStimulus(0, 7);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    m_en = '0; m_err_cnt = '0; m_err_code = '0; m_func = '0; m_ch = '0; m_pay = '0;
    check_state("mid_reset");
    checkOutput("mid_reset.no_commit", 80'(valid_seen - v0), 80'(0));

    for (int k = 0; k < 25; k++) begin
      p = {$urandom(), $urandom(), $urandom()};
      case ($urandom_range(0, 4))
        0, 1: f = 8'h01;
        2, 3: f = 8'h02;
        default: f = 8'($urandom());
      endcase
      case ($urandom_range(0, 7))
        0: c = 8'h00;
        5: c = 8'h05;
        6: c = 8'hFF;
        7: c = 8'($urandom());
        default: c = 8'($urandom_range(1, 4));
      endcase
      cx = 8'h00;
      ft = 8'hAA;
      case ($urandom_range(0, 7))
        0: cx = 8'($urandom_range(1, 255));
        1: ft = 8'hAA ^ 8'($urandom_range(1, 255));
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) frame_q.push_back(8'h56 + 8'($urandom_range(0, 100)));
      make_frame(f, c, p, cx, ft, 1'b1);
      applyStimulus($urandom_range(0, 3), -1);
      check_state($sformatf("rand%0d", k));
    end

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
